vga_scanout: RTL

Scanout stage that drives the VGA connector from the 214×160, 3bpp framebuffer. Generates 640×480@60 Hz timing from the 50 MHz system clock, upscales each framebuffer pixel 3×3, issues read addresses on the framebuffer's port A, and aligns the returned pixel data with sync and blanking. Sits between the framebuffer and the board pins, and gives the rasterizer a frame-boundary pulse for tear-free drawing.

---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_timing.sv | 53 +++++
 rtl/vga_scanout.sv | 125 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared geometry constants and types for the VGA scanout path.
// Contents: framebuffer size, 640x480@60 horizontal/vertical timing constants, pixel_t.
package vga_pkg;
    localparam int         FB_ADDR_W = 16;
    localparam logic [15:0] FB_WIDTH  = 16'd214;
    localparam logic [15:0] FB_HEIGHT = 16'd160;
    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FRONT   = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_TOTAL   = 10'd800;
    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FRONT   = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_TOTAL   = 10'd525;
    typedef logic [2:0] pixel_t;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: 25 MHz pixel enable plus 800x525 raster counters for 640x480@60.
// Ports: clk, rst (async, active-high); o_pix_en pixel-rate strobe; o_visible, o_hsync_n,
// o_vsync_n, o_vblank decoded from the current (h,v); o_line_wrap / o_frame_wrap /
// o_vblank_start are one-clk strobes on the pix_en clk that ends a line / frame / line 479.
module vga_timing
    import vga_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic o_pix_en,
    output logic o_visible,
    output logic o_hsync_n,
    output logic o_vsync_n,
    output logic o_vblank,
    output logic o_line_wrap,
    output logic o_frame_wrap,
    output logic o_vblank_start
);
    logic       r_pix_en;
    logic [9:0] r_h, r_v;
    logic [9:0] w_h_next, w_v_next;
    logic       w_line_wrap, w_frame_wrap;

    always_comb begin
        w_line_wrap  = r_pix_en && (r_h == H_TOTAL - 10'd1);
        w_frame_wrap = w_line_wrap && (r_v == V_TOTAL - 10'd1);
        w_h_next     = !r_pix_en ? r_h : w_line_wrap ? 10'd0 : r_h + 10'd1;
        w_v_next     = !w_line_wrap ? r_v : w_frame_wrap ? 10'd0 : r_v + 10'd1;
    end

    // Counters are rewritten every clk (holding when idle) so their value is always the
    // registered next-state, never an implicit hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_en <= 1'b0;
            r_h      <= 10'd0;
            r_v      <= 10'd0;
        end else begin
            r_pix_en <= !r_pix_en;
            r_h      <= w_h_next;
            r_v      <= w_v_next;
        end
    end

    assign o_pix_en       = r_pix_en;
    assign o_visible      = (r_h < H_VISIBLE) && (r_v < V_VISIBLE);
    assign o_hsync_n      = !((r_h >= H_VISIBLE + H_FRONT) && (r_h < H_VISIBLE + H_FRONT + H_SYNC));
    assign o_vsync_n      = !((r_v >= V_VISIBLE + V_FRONT) && (r_v < V_VISIBLE + V_FRONT + V_SYNC));
    assign o_vblank       = r_v >= V_VISIBLE;
    assign o_line_wrap    = w_line_wrap;
    assign o_frame_wrap   = w_frame_wrap;
    assign o_vblank_start = w_line_wrap && (r_v == V_VISIBLE - 10'd1);
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: drives the VGA pins from the 214x160 3bpp framebuffer, each pixel shown 3x3.
// Ports: clk, rst (async, active-high); fb_addr/fb_data framebuffer port A (1-clk read
// latency); vga_r/g/b colour pins; vga_hsync/vga_vsync active-low syncs; vblank high for
// v >= 480; frame_start one-clk pulse on entry to vblank.
// Build option: define VGA_TESTPATTERN_EN to show fb_x[4:2] colour bars instead of fb_data.
module vga_scanout
    import vga_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  pixel_t               fb_data,
    output logic                 vga_r,
    output logic                 vga_g,
    output logic                 vga_b,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 vblank,
    output logic                 frame_start
);
    logic w_pix_en, w_visible, w_hsync_n, w_vsync_n, w_vblank;
    logic w_line_wrap, w_frame_wrap, w_vblank_start;

    vga_timing u_timing (
        .clk           (clk),
        .rst           (rst),
        .o_pix_en      (w_pix_en),
        .o_visible     (w_visible),
        .o_hsync_n     (w_hsync_n),
        .o_vsync_n     (w_vsync_n),
        .o_vblank      (w_vblank),
        .o_line_wrap   (w_line_wrap),
        .o_frame_wrap  (w_frame_wrap),
        .o_vblank_start(w_vblank_start)
    );

    // fb_x runs past 213 through horizontal blanking (up to 266), hence 9 bits.
    logic [8:0]  r_fb_x, w_fb_x_next;
    logic [1:0]  r_hsub, w_hsub_next, r_vsub, w_vsub_next;
    logic [15:0] r_row_base, w_row_base_next;
    logic        w_hsub_wrap, w_vsub_wrap;

    always_comb begin
        w_hsub_wrap     = r_hsub == 2'd2;
        w_vsub_wrap     = r_vsub == 2'd2;
        w_hsub_next     = r_hsub;
        w_fb_x_next     = r_fb_x;
        w_vsub_next     = r_vsub;
        w_row_base_next = r_row_base;
        if (w_frame_wrap) begin
            w_hsub_next     = 2'd0;
            w_fb_x_next     = 9'd0;
            w_vsub_next     = 2'd0;
            w_row_base_next = 16'd0;
        end else if (w_line_wrap) begin
            w_hsub_next     = 2'd0;
            w_fb_x_next     = 9'd0;
            w_vsub_next     = w_vsub_wrap ? 2'd0 : r_vsub + 2'd1;
            w_row_base_next = w_vsub_wrap ? r_row_base + FB_WIDTH : r_row_base;
        end else if (w_pix_en) begin
            w_hsub_next = w_hsub_wrap ? 2'd0 : r_hsub + 2'd1;
            w_fb_x_next = w_hsub_wrap ? r_fb_x + 9'd1 : r_fb_x;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsub     <= 2'd0;
            r_fb_x     <= 9'd0;
            r_vsub     <= 2'd0;
            r_row_base <= 16'd0;
        end else begin
            r_hsub     <= w_hsub_next;
            r_fb_x     <= w_fb_x_next;
            r_vsub     <= w_vsub_next;
            r_row_base <= w_row_base_next;
        end
    end

    // Gating to 0 outside the visible area keeps every address below 34240.
    assign fb_addr = w_visible ? r_row_base + {7'd0, r_fb_x} : '0;

    // One-clk delay of the raster flags so they meet fb_data, which lags fb_addr by a clk.
    logic   r_vis_d, r_hs_d, r_vs_d;
    pixel_t w_pix;
`ifdef VGA_TESTPATTERN_EN
    pixel_t r_pat_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pat_d <= '0;
        else     r_pat_d <= r_fb_x[4:2];
    end
    assign w_pix = r_pat_d;
`else
    assign w_pix = fb_data;
`endif

    pixel_t r_rgb;
    logic   r_hsync, r_vsync, r_frame_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vis_d       <= 1'b0;
            r_hs_d        <= 1'b1;
            r_vs_d        <= 1'b1;
            r_rgb         <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_vis_d       <= w_visible;
            r_hs_d        <= w_hsync_n;
            r_vs_d        <= w_vsync_n;
            r_rgb         <= r_vis_d ? w_pix : '0;
            r_hsync       <= r_hs_d;
            r_vsync       <= r_vs_d;
            r_frame_start <= w_vblank_start;
        end
    end

    assign {vga_r, vga_g, vga_b} = r_rgb;
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign vblank      = w_vblank;
    assign frame_start = r_frame_start;
endmodule
